// File: rtl/asyn_fifo_param.sv
// Parametrised dual-clock FIFO with Gray-coded pointer crossing, per-domain
// reset synchronisers, registered fill levels, almost flags and sticky errors.
module asyn_fifo_param #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6,
  parameter int AE_THRESH   = 1
) (
  input  logic              WCLK,
  input  logic              RST_N,
  input  logic              RCLK,
  input  logic              WD,
  input  logic [WIDTH-1:0]  DATA_IN,
  output logic              WFULL,
  output logic              WALMOST_FULL,
  output logic [ADDR_W:0]   WLEVEL,
  output logic              WOVF,
  input  logic              RD,
  output logic [WIDTH-1:0]  DATA_OUT,
  output logic              RVALID,
  output logic              REMPTY,
  output logic              RALMOST_EMPTY,
  output logic [ADDR_W:0]   RLEVEL,
  output logic              RUDF
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL    = AE_THRESH[ADDR_W:0];
  // Full means the write pointer is exactly one lap ahead: top two Gray bits differ
  localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [SYNC_STAGES-1:0] wrst_sync, rrst_sync;
  logic                   wrst_n, rrst_n;
  logic [ADDR_W:0]        wbin, wgray, rbin, rgray;
  logic [ADDR_W:0]        rgray_w [SYNC_STAGES];
  logic [ADDR_W:0]        wgray_r [SYNC_STAGES];
  logic                   wr_en, rd_en;
  logic [ADDR_W:0]        wbin_next, wgray_next, wlevel_next;
  logic [ADDR_W:0]        rbin_next, rgray_next, rlevel_next;

  // Assert asynchronously, release after SYNC_STAGES edges of each local clock
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) wrst_sync <= '0;
    else        wrst_sync <= {wrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge RCLK or negedge RST_N) begin
    if (!RST_N) rrst_sync <= '0;
    else        rrst_sync <= {rrst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign wrst_n = wrst_sync[SYNC_STAGES-1];
  assign rrst_n = rrst_sync[SYNC_STAGES-1];

  always_ff @(posedge WCLK or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rgray_w[i] <= '0;
    end else begin
      rgray_w[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_w[i] <= rgray_w[i-1];
    end
  end

  always_ff @(posedge RCLK or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wgray_r[i] <= '0;
    end else begin
      wgray_r[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_r[i] <= wgray_r[i-1];
    end
  end

  // Flags and levels look at the post-access pointer so they settle on the same edge
  always_comb begin
    wr_en       = WD & ~WFULL;
    wbin_next   = wbin + {{ADDR_W{1'b0}}, wr_en};
    wgray_next  = bin2gray(wbin_next);
    wlevel_next = wbin_next - gray2bin(rgray_w[SYNC_STAGES-1]);
    rd_en       = RD & ~REMPTY;
    rbin_next   = rbin + {{ADDR_W{1'b0}}, rd_en};
    rgray_next  = bin2gray(rbin_next);
    rlevel_next = gray2bin(wgray_r[SYNC_STAGES-1]) - rbin_next;
  end

  always_ff @(posedge WCLK) begin
    if (wr_en) mem[wbin[ADDR_W-1:0]] <= DATA_IN;
  end

  always_ff @(posedge WCLK or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wgray        <= '0;
      WFULL        <= 1'b0;
      WALMOST_FULL <= (AF_THRESH == 0);
      WLEVEL       <= '0;
      WOVF         <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      WFULL        <= (wgray_next == (rgray_w[SYNC_STAGES-1] ^ FULL_MASK));
      WALMOST_FULL <= (wlevel_next >= AF_LVL);
      WLEVEL       <= wlevel_next;
      WOVF         <= WOVF | (WD & WFULL);
    end
  end

  always_ff @(posedge RCLK or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rgray         <= '0;
      REMPTY        <= 1'b1;
      RALMOST_EMPTY <= 1'b1;
      RLEVEL        <= '0;
      RUDF          <= 1'b0;
      RVALID        <= 1'b0;
      DATA_OUT      <= '0;
    end else begin
      rbin          <= rbin_next;
      rgray         <= rgray_next;
      REMPTY        <= (rgray_next == wgray_r[SYNC_STAGES-1]);
      RALMOST_EMPTY <= (rlevel_next <= AE_LVL);
      RLEVEL        <= rlevel_next;
      RUDF          <= RUDF | (RD & REMPTY);
      RVALID        <= rd_en;
      if (rd_en) DATA_OUT <= mem[rbin[ADDR_W-1:0]];
    end
  end

endmodule
